// File: rtl/event_simulation_pkg.sv
// Shared definitions for the event simulation core: function-select encodings
// and the Boolean evaluator used to form the registered result.
package event_simulation_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam int         OP_MAX  = 5;

    function automatic logic op_eval(input logic [2:0] op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/event_simulation_sync.sv
// N-flop input synchronizer with synchronous active-high reset; a depth of
// zero degenerates to a plain wire.
module event_simulation_sync
    import event_simulation_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_flops
            logic [DEPTH-1:0] stage_r;

            // Shift chain: stage 0 captures the raw input, the last stage feeds q.
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_r <= '0;
                end else begin
                    stage_r[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign q = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/event_simulation_core.sv
// Registered two-input event combiner: clocked Boolean result of the sampled
// pair plus change-event pulse, saturating event count and result edge pulses.
module event_simulation_core
    import event_simulation_pkg::*;
#(
    parameter int OP          = 0,
    parameter int SYNC_STAGES = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    output logic             c,
    output logic             evt,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             c_rise,
    output logic             c_fall
);

    generate
        if (OP < 0 || OP > OP_MAX) begin : g_bad_op
            $error("event_simulation_core: OP out of range 0..5");
        end
        if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
            $error("event_simulation_core: SYNC_STAGES out of range 0..3");
        end
        if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt
            $error("event_simulation_core: CNT_W out of range 2..32");
        end
    endgenerate

    localparam logic [2:0] OP_SEL = OP[2:0];

    logic       a_s;
    logic       b_s;
    logic [1:0] pair_s;
    logic       op_s;
    logic       cnt_full_s;
    logic [1:0] prev_r;

    event_simulation_sync #(.DEPTH(SYNC_STAGES)) u_sync_a (
        .clk (clk),
        .rst (rst),
        .d   (a),
        .q   (a_s)
    );

    event_simulation_sync #(.DEPTH(SYNC_STAGES)) u_sync_b (
        .clk (clk),
        .rst (rst),
        .d   (b),
        .q   (b_s)
    );

    // Next-state terms derived from the current synchronized sample.
    always_comb begin
        pair_s     = {a_s, b_s};
        op_s       = op_eval(OP_SEL, a_s, b_s);
        cnt_full_s = (evt_cnt == {CNT_W{1'b1}});
    end

    // Result, history compare, edge pulses and the saturating event counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r  <= 2'b00;
            c       <= 1'b0;
            evt     <= 1'b0;
            c_rise  <= 1'b0;
            c_fall  <= 1'b0;
            evt_cnt <= '0;
        end else begin
            prev_r <= pair_s;
            c      <= op_s;
            evt    <= (pair_s != prev_r);
            c_rise <= ~c & op_s;
            c_fall <= c & ~op_s;
            // The count trails evt by one edge and sticks at all-ones.
            if (evt && !cnt_full_s) begin
                evt_cnt <= evt_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                evt_cnt <= evt_cnt;
            end
        end
    end

endmodule

// File: tb/tb_event_simulation_core.sv
// Scoreboard bench: four configurations share one stimulus stream; each applied
// vector carries hand-computed expectations that a negedge monitor checks.
module tb_event_simulation_core;

    logic clk;
    logic rst;
    logic a;
    logic b;

    logic       m_c, m_evt, m_rise, m_fall;
    logic [7:0] m_cnt;
    logic       x_c, x_evt, x_rise, x_fall;
    logic [7:0] x_cnt;
    logic       s_c, s_evt, s_rise, s_fall;
    logic [1:0] s_cnt;
    logic       l_c, l_evt, l_rise, l_fall;
    logic [7:0] l_cnt;

    // m: AND, direct sampling; x: XOR; s: 2-bit counter; l: two sync stages
    event_simulation_core #(.OP(0), .SYNC_STAGES(0), .CNT_W(8)) u_m (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(m_c), .evt(m_evt),
        .evt_cnt(m_cnt), .c_rise(m_rise), .c_fall(m_fall));
    event_simulation_core #(.OP(2), .SYNC_STAGES(0), .CNT_W(8)) u_x (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(x_c), .evt(x_evt),
        .evt_cnt(x_cnt), .c_rise(x_rise), .c_fall(x_fall));
    event_simulation_core #(.OP(0), .SYNC_STAGES(0), .CNT_W(2)) u_s (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(s_c), .evt(s_evt),
        .evt_cnt(s_cnt), .c_rise(s_rise), .c_fall(s_fall));
    event_simulation_core #(.OP(0), .SYNC_STAGES(2), .CNT_W(8)) u_l (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(l_c), .evt(l_evt),
        .evt_cnt(l_cnt), .c_rise(l_rise), .c_fall(l_fall));

    typedef struct {
        int         idx;
        logic       a, b, rst, g;
        logic       mc, mevt;
        logic [7:0] mcnt;
        logic       xc;
        logic [1:0] scnt;
        logic       lc, levt;
        logic [7:0] lcnt;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_applied = 0;
    int   n_miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input int a_i, input int b_i, input int rst_i, input int g_i,
                       input int mc, input int mevt, input int mcnt, input int xc,
                       input int scnt, input int lc, input int levt, input int lcnt);
        vec_t v;
        v.idx  = vecs.size();
        v.a    = a_i[0];
        v.b    = b_i[0];
        v.rst  = rst_i[0];
        v.g    = g_i[0];
        v.mc   = mc[0];
        v.mevt = mevt[0];
        v.mcnt = mcnt[7:0];
        v.xc   = xc[0];
        v.scnt = scnt[1:0];
        v.lc   = lc[0];
        v.levt = levt[0];
        v.lcnt = lcnt[7:0];
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s vec %0d: got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    // Monitor: previous expected c per configuration to derive edge pulses.
    logic pm = 1'b0;
    logic px = 1'b0;
    logic pl = 1'b0;

    always @(negedge clk) begin
        vec_t e;
        logic mr, mf, xr, xf, lr, lf;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            n_applied++;
            mr = !e.rst & !pm & e.mc;
            mf = !e.rst & pm & !e.mc;
            xr = !e.rst & !px & e.xc;
            xf = !e.rst & px & !e.xc;
            lr = !e.rst & !pl & e.lc;
            lf = !e.rst & pl & !e.lc;
            chk("m_c",      e.idx, 32'(m_c),    32'(e.mc));
            chk("m_evt",    e.idx, 32'(m_evt),  32'(e.mevt));
            chk("m_cnt",    e.idx, 32'(m_cnt),  32'(e.mcnt));
            chk("m_rise",   e.idx, 32'(m_rise), 32'(mr));
            chk("m_fall",   e.idx, 32'(m_fall), 32'(mf));
            chk("x_c",      e.idx, 32'(x_c),    32'(e.xc));
            chk("x_evt",    e.idx, 32'(x_evt),  32'(e.mevt));
            chk("x_cnt",    e.idx, 32'(x_cnt),  32'(e.mcnt));
            chk("x_rise",   e.idx, 32'(x_rise), 32'(xr));
            chk("x_fall",   e.idx, 32'(x_fall), 32'(xf));
            chk("s_c",      e.idx, 32'(s_c),    32'(e.mc));
            chk("s_evt",    e.idx, 32'(s_evt),  32'(e.mevt));
            chk("s_cnt",    e.idx, 32'(s_cnt),  32'(e.scnt));
            chk("s_rise",   e.idx, 32'(s_rise), 32'(mr));
            chk("s_fall",   e.idx, 32'(s_fall), 32'(mf));
            chk("l_c",      e.idx, 32'(l_c),    32'(e.lc));
            chk("l_evt",    e.idx, 32'(l_evt),  32'(e.levt));
            chk("l_cnt",    e.idx, 32'(l_cnt),  32'(e.lcnt));
            chk("l_rise",   e.idx, 32'(l_rise), 32'(lr));
            chk("l_fall",   e.idx, 32'(l_fall), 32'(lf));
            pm = e.mc;
            px = e.xc;
            pl = e.lc;
        end
    end

    initial begin
        //   a  b rst g | mc mevt mcnt | xc | scnt | lc levt lcnt
        add(1, 1, 1, 0,   0, 0,  0,     0,   0,     0, 0,  0);   // reset, inputs high
        add(1, 1, 1, 0,   0, 0,  0,     0,   0,     0, 0,  0);
        add(1, 0, 0, 0,   0, 1,  0,     1,   0,     0, 0,  0);   // truth table 10
        add(0, 1, 0, 0,   0, 1,  1,     1,   1,     0, 0,  0);   // 01
        add(1, 1, 0, 0,   1, 1,  2,     0,   2,     0, 1,  0);   // 11
        add(0, 0, 0, 0,   0, 1,  3,     0,   3,     0, 1,  1);   // 00
        add(0, 0, 0, 0,   0, 0,  4,     0,   3,     1, 1,  2);   // count lands at 4
        add(0, 0, 0, 1,   0, 0,  4,     0,   3,     0, 1,  3);   // sub-cycle pulse on a
        add(1, 1, 0, 0,   1, 1,  4,     0,   3,     0, 0,  4);   // 00 -> 11 together
        add(1, 1, 0, 0,   1, 0,  5,     0,   3,     0, 0,  4);
        add(0, 1, 0, 0,   0, 1,  5,     1,   3,     1, 1,  4);   // toggle a x6
        add(1, 1, 0, 0,   1, 1,  6,     0,   3,     1, 0,  5);
        add(0, 1, 0, 0,   0, 1,  7,     1,   3,     0, 1,  5);
        add(1, 1, 0, 0,   1, 1,  8,     0,   3,     1, 1,  6);
        add(0, 1, 0, 0,   0, 1,  9,     1,   3,     0, 1,  7);
        add(1, 1, 0, 0,   1, 1, 10,     0,   3,     1, 1,  8);
        add(1, 1, 0, 0,   1, 0, 11,     0,   3,     0, 1,  9);
        add(1, 1, 0, 0,   1, 0, 11,     0,   3,     1, 1, 10);
        add(1, 1, 1, 0,   0, 0,  0,     0,   0,     0, 0,  0);   // reset from saturation
        add(0, 0, 0, 0,   0, 0,  0,     0,   0,     0, 0,  0);
        add(1, 1, 0, 0,   1, 1,  0,     0,   0,     0, 0,  0);   // latency step
        add(1, 1, 0, 0,   1, 0,  1,     0,   1,     0, 0,  0);
        add(1, 1, 0, 0,   1, 0,  1,     0,   1,     1, 1,  0);   // synced path 3 edges on
        add(1, 1, 0, 0,   1, 0,  1,     0,   1,     1, 0,  1);

        rst = 1'b1;
        a   = 1'b0;
        b   = 1'b0;
        @(posedge clk);
        #2;
        foreach (vecs[i]) begin
            a   = vecs[i].a;
            b   = vecs[i].b;
            rst = vecs[i].rst;
            if (vecs[i].g) begin
                #1 a = 1'b1;
                #1 a = 1'b0;
            end
            @(posedge clk);
            exp_q.push_back(vecs[i]);
            #2;
        end
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_miscompares++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
